// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the symmetric FIR front end.
package fir_pkg;

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic int nout(input int taps);
    return (taps + 1) / 2;
  endfunction

  function automatic int idx_w(input int taps);
    int n;
    n = nout(taps);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line: shift-in at dl[0], synchronous clear, full parallel read-out.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAPS   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     shift_en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dl [TAPS]
);

  // clr together with shift_en lands the new sample in an otherwise empty line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) dl[i] <= '0;
    end else if (shift_en) begin
      dl[0] <= din;
      for (int i = 1; i < TAPS; i++) dl[i] <= clr ? '0 : dl[i-1];
    end else if (clr) begin
      for (int i = 0; i < TAPS; i++) dl[i] <= '0;
    end
  end

endmodule

// File: rtl/fir_sym_preadd_seq.sv
// Symmetric FIR front end: one sample in, then (TAPS+1)/2 pre-added pairs out.
module fir_sym_preadd_seq
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAPS   = 16,
  localparam int NOUT  = nout(TAPS),
  localparam int IW    = idx_w(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W:0]   m_sum,
  output logic [IW-1:0]            m_idx,
  output logic                     m_last
);

  function automatic logic signed [DATA_W:0] sext(input logic signed [DATA_W-1:0] v);
    return {v[DATA_W-1], v};
  endfunction

  state_t                     state;
  logic [IW-1:0]              idx;
  logic signed [DATA_W-1:0]   dl [TAPS];
  logic                       vld_p0;
  logic                       last_p0;
  logic signed [DATA_W:0]     sum_p0;

  fir_delay_line #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_dl (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (state == IDLE && s_valid),
    .clr      (state == IDLE && flush),
    .din      (s_data),
    .dl       (dl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            state <= EMIT;
            idx   <= '0;
          end
        end
        EMIT: begin
          if (m_ready) begin
            if (last_p0) begin
              state <= IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // stage p0: pair select and pre-add straight from the held delay line
  assign vld_p0  = (state == EMIT);
  assign last_p0 = vld_p0 && (idx == IW'(NOUT - 1));

  always_comb begin
    sum_p0 = '0;
    if (vld_p0) begin
      for (int k = 0; k < NOUT; k++) begin
        if (idx == IW'(k)) begin
          // the odd-TAPS centre tap has no partner and passes through undoubled
          if (k < TAPS / 2) sum_p0 = sext(dl[k]) + sext(dl[TAPS-1-k]);
          else              sum_p0 = sext(dl[k]);
        end
      end
    end
  end

  assign s_ready = (state == IDLE);
  assign m_valid = vld_p0;
  assign m_sum   = sum_p0;
  assign m_idx   = idx;
  assign m_last  = last_p0;

endmodule

// File: doc/fir_sym_preadd_seq.md
Name: fir_sym_preadd_seq

Overview:
- Front-end stage of the symmetric FIR. Accepts one input sample per handshake and shifts it into a TAPS-deep delay line.
- Then emits, one per cycle, the symmetric pre-added pairs x[k] + x[TAPS-1-k], followed by the unpaired centre tap when TAPS is odd.
- Downstream coefficient MAC consumes these with the tap index. m_last marks the end of each output burst.

Parameters:
- DATA_W, 16: signed input sample width.
- TAPS, 16: filter length, must be >= 2, odd or even. NOUT = (TAPS+1)/2 outputs per sample.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  clears the delay line to zero (honoured only in IDLE).
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  DATA_W  signed input sample.
- m_valid  out  1  pre-added output valid.
- m_ready  in  1  downstream accepts the output.
- m_sum  out  DATA_W+1  signed pre-added pair, or the sign-extended centre tap.
- m_idx  out  $clog2(NOUT) (min 1)  tap/coefficient index, 0..NOUT-1.
- m_last  out  1  high on the final output of the burst (m_idx == NOUT-1).

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE, delay line dl[0..TAPS-1] = 0, idx = 0.
  - m_valid = 0, m_last = 0, m_idx = 0, m_sum = 0.
  - s_ready = 1 (combinational: state == IDLE).
- IDLE:
  - s_ready = 1, m_valid = 0.
  - On s_valid: dl[0] <= s_data, dl[i] <= dl[i-1], idx <= 0, state <= EMIT.
  - Else if flush: all dl <= 0. Flush with s_valid in the same cycle: sample is shifted into the cleared line, so dl[0] = s_data and all others = 0.
- EMIT:
  - s_ready = 0; s_valid is ignored and the sample is not captured. flush is ignored.
  - m_valid = 1. m_idx = idx. m_last = (idx == NOUT-1).
  - m_sum = sext(dl[idx]) + sext(dl[TAPS-1-idx]) when idx < TAPS/2.
  - m_sum = sext(dl[(TAPS-1)/2]) for the odd-TAPS centre index. The centre value is not doubled.
  - On m_valid && m_ready: if m_last then state <= IDLE, idx <= 0; else idx <= idx+1.
  - While m_valid && !m_ready, m_sum, m_idx and m_last are held stable. The delay line does not change in EMIT.
- Timing:
  - Sample accepted at edge t; first m_valid visible after edge t, held until the handshake.
  - With m_ready held high: NOUT output cycles, then 1 IDLE cycle. Maximum throughput is 1 sample per NOUT+1 cycles.
- Arithmetic:
  - Both operands are sign-extended to DATA_W+1 bits before addition. No overflow is possible; no saturation, no rounding.
- Boundary conditions:
  - idx never exceeds NOUT-1.
  - TAPS = 2: NOUT = 1, so every output has m_last = 1.
  - Reset mid-EMIT: the burst is aborted, outputs return to reset values and the delay line is zeroed.
  - m_ready high in IDLE has no effect.

Decomposition:
- Package fir_pkg:
  - state enum {IDLE, EMIT};
  - function nout(TAPS) returning (TAPS+1)/2;
  - function idx_w(TAPS) returning max(1, $clog2(nout)).
- One sub-module, fir_delay_line:
  - parameterised shift register with shift enable, synchronous clear and full parallel read-out;
  - the top level contains the FSM, index counter, pair mux and adder.

Test Plan:
- TAPS=4, DATA_W=8, m_ready=1, push 1,2,3,4 -> after 4th push bursts (sum=5, idx=0, last=0), (sum=5, idx=1, last=1). First burst after reset is (1, 0), (0, 1).
- TAPS=5, push 1..5 -> m_sum 6, 6, 3 with idx 0, 1, 2; last only on idx 2. Centre not doubled.
- TAPS=4, DATA_W=8, push 127 x4 -> m_sum = 254 both outputs. Push -128 x4 -> m_sum = -256 (9-bit signed).
- Backpressure: m_ready low 3 cycles during idx 0 -> m_valid, m_sum, m_idx stable for those cycles; idx advances only on handshake. s_valid pulsed in EMIT -> s_ready = 0 and the sample is not taken (next burst sums unchanged).
- flush in IDLE after samples 1..4 -> next push of 7 gives sums (7, 0).
- rst_n low mid-EMIT (TAPS=4, at idx=1) -> immediate m_valid = 0, s_ready = 1. Next push of 9 -> sums (9, 0).
